// File: rtl/regfile_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_shift_unit
//  Purpose  : 32 x 64-bit integer register file with two combinational read
//             ports and one synchronous write port. It also holds the
//             immediate-shift datapath (SLLI/SRLI/SRAI) that shifts read
//             port 1 data by Inst[25:20].
//  Options  : RF_WRITE_BYPASS_EN - when defined, a read port that addresses
//             the register being written in this cycle returns WriteData.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_shift_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic [4:0]  WriteReg,
    input  logic [63:0] WriteData,
    input  logic [31:0] Inst,
    input  logic [1:0]  Shift,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic [5:0]  ShiftN,
    output logic [63:0] ShiftOut
);

    localparam logic [1:0] c_SH_SLL  = 2'b00;
    localparam logic [1:0] c_SH_SRL  = 2'b01;
    localparam logic [1:0] c_SH_SRA  = 2'b10;

    logic [63:0] r_regs [0:31];

    logic        w_wr_en;
    logic [63:0] w_rd1;
    logic [63:0] w_rd2;
    logic [5:0]  w_shamt;
    logic [63:0] w_sra;
    logic [63:0] w_shift_out;
    logic        w_unused_inst;

    // A write only takes effect outside reset and never targets x0.
    assign w_wr_en = RegWrite && !Reset && (WriteReg != 5'd0);

    // Register array: reset clears every entry; otherwise a single write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 64'd0;
            end
        end else if (w_wr_en) begin
            r_regs[WriteReg] <= WriteData;
        end
    end

    // Read ports: x0 is hardwired to zero; optional forwarding of the write.
    always_comb begin
        w_rd1 = 64'd0;
        w_rd2 = 64'd0;
        if (ReadReg1 != 5'd0) begin
            w_rd1 = r_regs[ReadReg1];
        end
        if (ReadReg2 != 5'd0) begin
            w_rd2 = r_regs[ReadReg2];
        end
`ifdef RF_WRITE_BYPASS_EN
        // w_wr_en already excludes x0, so x0 is never forwarded.
        if (w_wr_en && (ReadReg1 == WriteReg)) begin
            w_rd1 = WriteData;
        end
        if (w_wr_en && (ReadReg2 == WriteReg)) begin
            w_rd2 = WriteData;
        end
`endif
    end

    // Shift amount is the 6-bit immediate field; the funct6 bits are ignored.
    assign w_shamt       = Inst[25:20];
    assign w_unused_inst = ^{Inst[31:26], Inst[19:0]};

    assign w_sra = $signed(w_rd1) >>> w_shamt;

    // Shifter selecting logical left, logical right, arithmetic right or pass.
    always_comb begin
        w_shift_out = w_rd1;
        case (Shift)
            c_SH_SLL: w_shift_out = w_rd1 << w_shamt;
            c_SH_SRL: w_shift_out = w_rd1 >> w_shamt;
            c_SH_SRA: w_shift_out = w_sra;
            default:  w_shift_out = w_rd1;
        endcase
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;
    assign ShiftN    = w_shamt;
    assign ShiftOut  = w_shift_out;

endmodule
`default_nettype wire

// File: tb/tb_regfile_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_shift_unit
//  Purpose  : Directed, table-driven self-checking bench for the register
//             file and immediate shifter, plus hand sequences for reset
//             priority and same-cycle write/read behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_shift_unit;

    logic        Clk;
    logic        Reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic [31:0] Inst;
    logic [1:0]  Shift;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [5:0]  ShiftN;
    logic [63:0] ShiftOut;

    int n_cmp;
    int n_bad;

    regfile_shift_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Inst      (Inst),
        .Shift     (Shift),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .ShiftN    (ShiftN),
        .ShiftOut  (ShiftOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] inst;
        logic [1:0]  sh;
        logic [63:0] e_rd1;
        logic [63:0] e_rd2;
        logic [5:0]  e_shn;
        logic [63:0] e_so;
    } vec_t;

    vec_t vecs [0:13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] inst, input logic [1:0] sh);
        RegWrite  = we;
        WriteReg  = wr;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
        Inst      = inst;
        Shift     = sh;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 32'd0, 2'b11);

        // Reads sample the state before the next edge; writes land at that edge.
        //          we  wr  wd                      r1  r2  inst          sh     rd1                     rd2                     shn  so
        vecs[0]  = '{1, 5,  64'h0123456789ABCDEF,   0,  0,  32'h0,        2'b00, 64'h0,                  64'h0,                  0,   64'h0};
        vecs[1]  = '{0, 0,  64'h0,                  5,  5,  32'h0,        2'b00, 64'h0123456789ABCDEF,   64'h0123456789ABCDEF,   0,   64'h0123456789ABCDEF};
        vecs[2]  = '{1, 0,  64'hFFFFFFFFFFFFFFFF,   5,  0,  32'h0,        2'b01, 64'h0123456789ABCDEF,   64'h0,                  0,   64'h0123456789ABCDEF};
        vecs[3]  = '{0, 0,  64'h0,                  0,  0,  32'h0,        2'b10, 64'h0,                  64'h0,                  0,   64'h0};
        vecs[4]  = '{1, 1,  64'h80000000000000F0,   5,  5,  32'h00400000, 2'b00, 64'h0123456789ABCDEF,   64'h0123456789ABCDEF,   4,   64'h123456789ABCDEF0};
        vecs[5]  = '{0, 0,  64'h0,                  1,  5,  32'h00400000, 2'b00, 64'h80000000000000F0,   64'h0123456789ABCDEF,   4,   64'h0000000000000F00};
        vecs[6]  = '{0, 0,  64'h0,                  1,  5,  32'h00400000, 2'b01, 64'h80000000000000F0,   64'h0123456789ABCDEF,   4,   64'h080000000000000F};
        vecs[7]  = '{0, 0,  64'h0,                  1,  5,  32'h00400000, 2'b10, 64'h80000000000000F0,   64'h0123456789ABCDEF,   4,   64'hF80000000000000F};
        vecs[8]  = '{0, 0,  64'h0,                  1,  5,  32'h00400000, 2'b11, 64'h80000000000000F0,   64'h0123456789ABCDEF,   4,   64'h80000000000000F0};
        vecs[9]  = '{1, 2,  64'h8000000000000000,   1,  1,  32'hFFF00000, 2'b10, 64'h80000000000000F0,   64'h80000000000000F0,   63,  64'hFFFFFFFFFFFFFFFF};
        vecs[10] = '{0, 0,  64'h0,                  2,  1,  32'hFFF00000, 2'b10, 64'h8000000000000000,   64'h80000000000000F0,   63,  64'hFFFFFFFFFFFFFFFF};
        vecs[11] = '{0, 0,  64'h0,                  2,  1,  32'hFFF00000, 2'b01, 64'h8000000000000000,   64'h80000000000000F0,   63,  64'h0000000000000001};
        vecs[12] = '{0, 0,  64'h0,                  2,  1,  32'hFFF00000, 2'b00, 64'h8000000000000000,   64'h80000000000000F0,   63,  64'h0};
        vecs[13] = '{0, 0,  64'h0,                  2,  1,  32'hFC0FFFFF, 2'b01, 64'h8000000000000000,   64'h80000000000000F0,   0,   64'h8000000000000000};

        // Reset, then sweep all indices on both ports.
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1[%0d]", i), ReadData1, 64'd0);
            check($sformatf("reset_rd2[%0d]", 31 - i), ReadData2, 64'd0);
        end
        check("reset_shiftout", ShiftOut, 64'd0);

        // Table-driven vectors.
        for (int v = 0; v < 14; v++) begin
            @(negedge Clk);
            drive(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r1, vecs[v].r2,
                  vecs[v].inst, vecs[v].sh);
            #1;
            check($sformatf("v%0d_rd1", v), ReadData1, vecs[v].e_rd1);
            check($sformatf("v%0d_rd2", v), ReadData2, vecs[v].e_rd2);
            check($sformatf("v%0d_shn", v), {58'd0, ShiftN}, {58'd0, vecs[v].e_shn});
            check($sformatf("v%0d_so", v), ShiftOut, vecs[v].e_so);
        end

        // Same-cycle write/read of x9: old value unless forwarding is built in.
        @(negedge Clk);
        drive(1'b1, 5'd9, 64'h55, 5'd9, 5'd9, 32'h0, 2'b11);
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("byp_rd1_same_cycle", ReadData1, 64'h55);
        check("byp_rd2_same_cycle", ReadData2, 64'h55);
        check("byp_so_same_cycle", ShiftOut, 64'h55);
`else
        check("nobyp_rd1_same_cycle", ReadData1, 64'h0);
        check("nobyp_rd2_same_cycle", ReadData2, 64'h0);
        check("nobyp_so_same_cycle", ShiftOut, 64'h0);
`endif
        @(negedge Clk);
        drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd5, 32'h0, 2'b11);
        #1;
        check("x9_after_edge", ReadData1, 64'h55);
        check("x5_retained", ReadData2, 64'h0123456789ABCDEF);

        // x7 written, then reset and a write to x7 on the same edge.
        @(negedge Clk);
        drive(1'b1, 5'd7, 64'hAA, 5'd0, 5'd0, 32'h0, 2'b11);
        @(negedge Clk);
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd1, 32'h0, 2'b11);
        #1;
        check("x7_written", ReadData1, 64'hAA);
        @(negedge Clk);
        Reset = 1'b1;
        drive(1'b1, 5'd7, 64'hBB, 5'd7, 5'd1, 32'h0, 2'b11);
        @(negedge Clk);
        Reset = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd1, 32'h00500000, 2'b11);
        #1;
        check("reset_beats_write_x7", ReadData1, 64'h0);
        check("reset_clears_x1", ReadData2, 64'h0);
        check("shiftn_indep_of_reset", {58'd0, ShiftN}, 64'd5);
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd9;
        #1;
        check("reset_clears_x5", ReadData1, 64'h0);
        check("reset_clears_x9", ReadData2, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
